wf_button_gesture: RTL and testbench
====================================

# wf_button_gesture

Classifies presses of the debounced user button into short-press, long-press and double-click events. It sits directly downstream of the switch debouncer and the 10 ms timer. It turns the debounced active-low level into single-cycle event pulses that the LED/blink-rate control logic consumes instead of raw push edges. All timing is counted in sample ticks, not clocks, so thresholds are in 10 ms units at the default tick.

## Interface
- LONG_TICKS, 100: ticks a press must be held to count as a long press (1 s at 10 ms tick); legal range 2..2**CNT_W-1.
- DCLICK_TICKS, 30: maximum ticks between first release and second press for a double click; legal range 2..2**CNT_W-1.
- CNT_W, 8: width of the internal tick counter.
- clk  in  1  main clock (WF_CLK domain).
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- tick  in  1  single-cycle sample pulse from the 10 ms timer.
- switch_n  in  1  debounced, synchronous button level; 0 = pushed.
- short_press  out  1  one-cycle pulse: short press recognised.
- long_press  out  1  one-cycle pulse: long-press threshold reached while still held.
- double_click  out  1  one-cycle pulse: second press released within window.
- held  out  1  level: high while in HOLD (long press still held).
- busy  out  1  level: high in any state other than IDLE.

## Operation
- Internal prev register samples switch_n every clock. A press edge is prev=1 and switch_n=0. A release edge is prev=0 and switch_n=1.
- The counter cnt clears on every state entry. It increments on tick and saturates at 2**CNT_W-1.
- State machine:
  - IDLE: press edge -> PRESS1.
  - PRESS1: release edge -> WAIT2, or -> IDLE with short_press when the double-click feature is compiled out. Tick with cnt==LONG_TICKS-1 -> HOLD with long_press.
  - WAIT2: press edge -> PRESS2. Tick with cnt==DCLICK_TICKS-1 -> IDLE with short_press.
  - PRESS2: release edge -> IDLE with double_click. Tick with cnt==LONG_TICKS-1 -> HOLD with long_press. The pending click is discarded in this case.
  - HOLD: release edge -> IDLE, with no further pulse.
- Simultaneous events:
  - In PRESS1/PRESS2, release in the same cycle as the threshold tick: release wins.
  - In WAIT2, press in the same cycle as the timeout tick: press wins.
- At most one event pulse is asserted in any cycle. Every press yields exactly one of short_press / long_press / double_click, or nothing if reset intervenes.
- tick ignored in IDLE and HOLD.

## Timing
- Reset values: state=IDLE, cnt=0, prev=0, and all outputs 0.
- Because prev resets to 0, a button held through reset deassertion is ignored until released and pressed again.
- Pulses are registered. A pulse is high for exactly the one cycle after the clock edge that sampled the causing condition.
- held and busy follow the registered state with no extra latency.
- Reset mid-operation aborts any gesture immediately and emits no pulse.
- Long-press latency: LONG_TICKS ticks after the press edge, counting the first tick after entry as tick 1.

## Configuration
- Macro: WF_DOUBLE_CLICK_EN.
- When defined: WAIT2 and PRESS2 exist. short_press is delayed until the DCLICK_TICKS window expires.
- When undefined:
  - WAIT2 and PRESS2 are removed and DCLICK_TICKS is unused.
  - short_press fires on the release edge in PRESS1.
  - double_click is tied to 0.

## Structure
- Shared package wf_button_pkg holds:
  - the state enum (IDLE, PRESS1, WAIT2, PRESS2, HOLD);
  - default constants for LONG_TICKS and DCLICK_TICKS at the 10 ms tick.
- No sub-module. Edge detection and the saturating counter stay inline; they are too small to justify one.

## Test plan
Bench settings for all scenarios: LONG_TICKS=10, DCLICK_TICKS=5, tick every 4 clocks.
- Press for 3 ticks, release, then idle 6 ticks -> short_press once, 5 ticks after release; no other pulses; busy falls the same cycle.
- Press and hold 12 ticks -> long_press once, at the 10th tick. held rises the next cycle and stays high until release. No pulse on release.
- Press 2 ticks, release, wait 2 ticks, press 2 ticks, release -> double_click once, one cycle after the second release edge; no short_press.
- Release coincident with the 10th tick in PRESS1, and press coincident with the timeout tick in WAIT2 -> release-wins and press-wins outcomes as specified.
- Assert rst for 2 cycles in PRESS1, with switch_n held at 0 through reset release -> no pulse; state stays IDLE until a release followed by a new press.
- Build without WF_DOUBLE_CLICK_EN: press 2 ticks, release -> short_press one cycle after the release edge; a second quick press/release gives a second short_press, and double_click stays 0.

Source files
------------

// File: rtl/wf_button_pkg.sv
// Shared types and default timing constants for the button gesture classifier.
package wf_button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    HOLD
  } gest_state_t;

  // Defaults assume the 10 ms sample tick.
  localparam int LONG_TICKS_DEF   = 100;
  localparam int DCLICK_TICKS_DEF = 30;

endpackage

// File: rtl/wf_button_gesture.sv
// Turns the debounced active-low button level into short/long/double-click pulses.
// Define WF_DOUBLE_CLICK_EN to build the double-click states (WAIT2/PRESS2).
module wf_button_gesture
  import wf_button_pkg::*;
#(
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int DCLICK_TICKS = DCLICK_TICKS_DEF,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic switch_n,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

  gest_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             prev;
  logic             press_e, rel_e, long_hit;
  logic             short_nxt, long_nxt;

  assign press_e  = prev & ~switch_n;
  assign rel_e    = ~prev & switch_n;
  assign long_hit = tick && (cnt == LONG_LAST);

`ifdef WF_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);
  logic dclick_nxt;
`else
  logic dclick_unused;
  assign dclick_unused = (DCLICK_TICKS != 0);
`endif

  // Release is tested before the threshold tick, and press before the timeout tick,
  // so the button edge wins when both land in the same cycle.
  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
`ifdef WF_DOUBLE_CLICK_EN
    dclick_nxt = 1'b0;
`endif
    case (state)
      IDLE: if (press_e) state_nxt = PRESS1;
      PRESS1: begin
        if (rel_e) begin
`ifdef WF_DOUBLE_CLICK_EN
          state_nxt = WAIT2;
`else
          state_nxt = IDLE;
          short_nxt = 1'b1;
`endif
        end else if (long_hit) begin
          state_nxt = HOLD;
          long_nxt  = 1'b1;
        end
      end
`ifdef WF_DOUBLE_CLICK_EN
      WAIT2: begin
        if (press_e) state_nxt = PRESS2;
        else if (tick && (cnt == DCLICK_LAST)) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end
      end
      PRESS2: begin
        if (rel_e) begin
          state_nxt  = IDLE;
          dclick_nxt = 1'b1;
        end else if (long_hit) begin
          state_nxt = HOLD;
          long_nxt  = 1'b1;
        end
      end
`endif
      HOLD: if (rel_e) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      prev        <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      prev        <= switch_n;
      state       <= state_nxt;
      short_press <= short_nxt;
      long_press  <= long_nxt;
      if (state_nxt != state)           cnt <= '0;
      else if (tick && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
    end
  end

`ifdef WF_DOUBLE_CLICK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) double_click <= 1'b0;
    else     double_click <= dclick_nxt;
  end
`else
  assign double_click = 1'b0;
`endif

  assign held = (state == HOLD);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_wf_button_gesture.sv
// Self-checking bench: gesture-level reference model checked every cycle, plus directed literals.
module tb_wf_button_gesture;

  localparam int LONG_T   = 10;
  localparam int DCLICK_T = 5;
`ifdef WF_DOUBLE_CLICK_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic switch_n = 1'b1;
  logic short_press, long_press, double_click, held, busy;

  wf_button_gesture #(
    .LONG_TICKS  (LONG_T),
    .DCLICK_TICKS(DCLICK_T),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .switch_n    (switch_n),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .held        (held),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int tphase = 0;
  int cyc = 0, tick_num = 0;

  // gesture model: active gesture, button down, in long-hold, number of presses, ticks in phase
  bit m_prev, m_act, m_down, m_lng;
  int m_presses, m_n;
  bit e_s, e_l, e_d;

  int press_tick, rel_tick, rel_cyc;
  int s_tick, s_cyc, l_tick, d_cyc;
  bit s_busy;
  int n_s = 0, n_l = 0, n_d = 0;

  function automatic bit next_tick();
    return ((tphase + 1) % 4) == 0;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic step(input bit sw, input bit r);
    bit pe, re;
    @(negedge clk);
    rst      = r;
    switch_n = sw;
    tphase   = (tphase + 1) % 4;
    tick     = (tphase == 0);
    @(posedge clk);
    cyc++;
    if (tick) tick_num++;
    e_s = 1'b0; e_l = 1'b0; e_d = 1'b0;
    if (r) begin
      m_prev = 1'b0; m_act = 1'b0; m_down = 1'b0; m_lng = 1'b0;
      m_presses = 0; m_n = 0;
    end else begin
      pe = m_prev && !sw;
      re = !m_prev && sw;
      m_prev = sw;
      if (pe) press_tick = tick_num;
      if (re) begin rel_tick = tick_num; rel_cyc = cyc; end
      if (!m_act) begin
        if (pe) begin m_act = 1; m_down = 1; m_lng = 0; m_presses = 1; m_n = 0; end
      end else if (m_lng) begin
        if (re) m_act = 0;
      end else if (m_down) begin
        if (re) begin
          if (m_presses == 2)  begin e_d = 1; m_act = 0; end
          else if (DC)         begin m_down = 0; m_n = 0; end
          else                 begin e_s = 1; m_act = 0; end
        end else if (tick) begin
          m_n++;
          if (m_n == LONG_T) begin e_l = 1; m_lng = 1; end
        end
      end else begin
        if (pe) begin m_down = 1; m_presses = 2; m_n = 0; end
        else if (tick) begin
          m_n++;
          if (m_n == DCLICK_T) begin e_s = 1; m_act = 0; end
        end
      end
    end
    #1;
    vectors++;
    if ({short_press, long_press, double_click, held, busy} !==
        {e_s, e_l, e_d, m_act && m_lng, m_act}) begin
      miscompares++;
      $display("FAIL cycle %0d s/l/d/held/busy: got %b%b%b%b%b, expected %b%b%b%b%b", cyc,
               short_press, long_press, double_click, held, busy,
               e_s, e_l, e_d, m_act && m_lng, m_act);
    end
    if (short_press === 1'b1) begin n_s++; s_tick = tick_num; s_cyc = cyc; s_busy = busy; end
    if (long_press === 1'b1)  begin n_l++; l_tick = tick_num; end
    if (double_click === 1'b1) begin n_d++; d_cyc = cyc; end
  endtask

  task automatic run(input bit sw, input int n);
    repeat (n) step(sw, 1'b0);
  endtask

  initial begin
    int s0, l0, d0, k;
    repeat (3) step(1'b1, 1'b1);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", short_press + long_press + double_click, 0);
    run(1'b1, 4);

    // short press: 3 ticks down, 6 ticks idle
    s0 = n_s; l0 = n_l; d0 = n_d;
    run(1'b0, 12); run(1'b1, 24);
    chk("s1_short_cnt", n_s - s0, 1);
    chk("s1_long_cnt", n_l - l0, 0);
    chk("s1_dclick_cnt", n_d - d0, 0);
    chk("s1_busy_at_pulse", s_busy, 0);
`ifdef WF_DOUBLE_CLICK_EN
    chk("s1_short_ticks_after_release", s_tick - rel_tick, 5);
`else
    chk("s1_short_cycle", s_cyc, rel_cyc);
`endif

    // long press: hold 12 ticks
    s0 = n_s; l0 = n_l; d0 = n_d;
    run(1'b0, 48);
    chk("s2_held_while_down", held, 1);
    run(1'b1, 30);
    chk("s2_long_cnt", n_l - l0, 1);
    chk("s2_short_cnt", n_s - s0, 0);
    chk("s2_long_tick", l_tick - press_tick, 10);
    chk("s2_held_after_release", held, 0);

    // double click
    s0 = n_s; l0 = n_l; d0 = n_d;
    run(1'b0, 8); run(1'b1, 8); run(1'b0, 8); run(1'b1, 30);
`ifdef WF_DOUBLE_CLICK_EN
    chk("s3_dclick_cnt", n_d - d0, 1);
    chk("s3_short_cnt", n_s - s0, 0);
    chk("s3_dclick_cycle", d_cyc, rel_cyc);
`else
    chk("s3_short_cnt", n_s - s0, 2);
    chk("s3_dclick_cnt", n_d - d0, 0);
    chk("s3_short_cycle", s_cyc, rel_cyc);
`endif

    // release on the 10th tick: release wins
    s0 = n_s; l0 = n_l; d0 = n_d;
    step(1'b0, 1'b0);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (next_tick() && k == 9) begin step(1'b1, 1'b0); break; end
      step(1'b0, 1'b0);
      if (tick) k++;
    end
    run(1'b1, 30);
    chk("s4a_long_cnt", n_l - l0, 0);
    chk("s4a_short_cnt", n_s - s0, 1);
`ifdef WF_DOUBLE_CLICK_EN
    chk("s4a_short_ticks_after_release", s_tick - rel_tick, 5);
`else
    chk("s4a_short_cycle", s_cyc, rel_cyc);
`endif

    // press on the WAIT2 timeout tick: press wins
    s0 = n_s; l0 = n_l; d0 = n_d;
    run(1'b0, 8);
    step(1'b1, 1'b0);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (next_tick() && k == 4) begin step(1'b0, 1'b0); break; end
      step(1'b1, 1'b0);
      if (tick) k++;
    end
    run(1'b0, 8); run(1'b1, 30);
`ifdef WF_DOUBLE_CLICK_EN
    chk("s4b_dclick_cnt", n_d - d0, 1);
    chk("s4b_short_cnt", n_s - s0, 0);
`else
    chk("s4b_short_cnt", n_s - s0, 2);
    chk("s4b_dclick_cnt", n_d - d0, 0);
`endif

    // reset in PRESS1 with the button held through reset release
    s0 = n_s; l0 = n_l; d0 = n_d;
    run(1'b0, 8);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    run(1'b0, 20);
    chk("s5_busy_held_through_reset", busy, 0);
    chk("s5_pulses_after_reset", (n_s - s0) + (n_l - l0) + (n_d - d0), 0);
    run(1'b1, 8); run(1'b0, 8); run(1'b1, 30);
    chk("s5_short_after_repress", n_s - s0, 1);

    // randomized gestures with occasional reset
    for (int g = 0; g < 250; g++) begin
      run(1'b0, $urandom_range(1, 56));
      if ($urandom_range(0, 19) == 0)
        repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b1);
      run(1'b1, $urandom_range(1, 36));
    end
    run(1'b1, 60);
    chk("final_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
